// File: rtl/qbus_slave.sv
// rtl/qbus_slave.sv - QBUS target engine answering DATI/DATO/DATOB cycles for claimed I/O-page registers.
// Define QSLAVE_DATIO_EN to accept a DOUT after DIN in one RSYNC (DATIO/DATIOB read-modify-write).
module qbus_slave #(
  parameter int REPLY_DELAY = 1,
  parameter int ADDR_BITS   = 13
) (
  input  logic                 qclk,
  input  logic                 reset,
  inout  wire  [21:0]          DAL,
  output logic                 DALtx,
  input  logic                 RSYNC,
  input  logic                 RDIN,
  input  logic                 RDOUT,
  input  logic                 RBS7,
  input  logic                 RWTBT,
  input  logic                 RINIT,
  output logic                 TRPLY,
  output logic [ADDR_BITS-1:0] iADDR,
  output logic                 iBS7,
  output logic                 iWRITE,
  output logic                 iBYTE,
  output logic [15:0]          iWDATA,
  input  logic [15:0]          iRDATA,
  input  logic                 iREAD_MATCH,
  input  logic                 iWRITE_MATCH
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_RD_LATCH,
    S_RD_DRV,
    S_RD_RPLY,
    S_WR,
    S_WR_RPLY,
    S_DONE,
    S_SKIP
  } state_t;

  state_t state_q, state_d;

  logic        rsync_q, rdin_q, rdout_q, rbs7_q, rwtbt_q;
  logic [15:0] dal_q;

  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 bs7_q, bs7_d;
  logic [15:0]          wdata_q, wdata_d;
  logic                 byte_q, byte_d;
  logic                 write_q, write_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 daltx_q, daltx_d;
  logic                 trply_q, trply_d;
  logic [2:0]           cnt_q, cnt_d;
`ifdef QSLAVE_DATIO_EN
  logic                 did_read_q, did_read_d;
`endif

  // RINIT bypasses the input registers so it clears the engine on the very next edge, like reset.
  always_ff @(posedge qclk) begin
    if (reset || RINIT) begin
      state_q    <= S_IDLE;
      rsync_q    <= 1'b0;
      rdin_q     <= 1'b0;
      rdout_q    <= 1'b0;
      rbs7_q     <= 1'b0;
      rwtbt_q    <= 1'b0;
      dal_q      <= 16'h0000;
      addr_q     <= '0;
      bs7_q      <= 1'b0;
      wdata_q    <= 16'h0000;
      byte_q     <= 1'b0;
      write_q    <= 1'b0;
      rdata_q    <= 16'h0000;
      daltx_q    <= 1'b0;
      trply_q    <= 1'b0;
      cnt_q      <= 3'd0;
`ifdef QSLAVE_DATIO_EN
      did_read_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rsync_q    <= RSYNC;
      rdin_q     <= RDIN;
      rdout_q    <= RDOUT;
      rbs7_q     <= RBS7;
      rwtbt_q    <= RWTBT;
      dal_q      <= DAL[15:0];
      addr_q     <= addr_d;
      bs7_q      <= bs7_d;
      wdata_q    <= wdata_d;
      byte_q     <= byte_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      daltx_q    <= daltx_d;
      trply_q    <= trply_d;
      cnt_q      <= cnt_d;
`ifdef QSLAVE_DATIO_EN
      did_read_q <= did_read_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bs7_d      = bs7_q;
    wdata_d    = wdata_q;
    byte_d     = byte_q;
    write_d    = 1'b0;
    rdata_d    = rdata_q;
    daltx_d    = daltx_q;
    trply_d    = trply_q;
    cnt_d      = cnt_q;
`ifdef QSLAVE_DATIO_EN
    did_read_d = did_read_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef QSLAVE_DATIO_EN
        did_read_d = 1'b0;
`endif
        if (rsync_q) begin
          addr_d  = dal_q[ADDR_BITS-1:0];
          bs7_d   = rbs7_q;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!bs7_q) begin
          state_d = S_SKIP;
        end else if (rdin_q) begin
          state_d = iREAD_MATCH ? S_RD_LATCH : S_SKIP;
        end else if (rdout_q) begin
          if (iWRITE_MATCH) begin
            wdata_d = dal_q;
            byte_d  = rwtbt_q;
            write_d = 1'b1;
            state_d = S_WR;
          end else begin
            state_d = S_SKIP;
          end
        end
      end
      S_RD_LATCH: begin
        rdata_d = iRDATA;
        daltx_d = 1'b1;
        cnt_d   = 3'(REPLY_DELAY - 1);
        state_d = S_RD_DRV;
      end
      S_RD_DRV: begin
        if (cnt_q == 3'd0) begin
          trply_d = 1'b1;
          state_d = S_RD_RPLY;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RD_RPLY: begin
        if (!rdin_q) begin
          daltx_d = 1'b0;
          trply_d = 1'b0;
          state_d = S_DONE;
`ifdef QSLAVE_DATIO_EN
          did_read_d = 1'b1;
`endif
        end
      end
      S_WR: begin
        trply_d = 1'b1;
        state_d = S_WR_RPLY;
      end
      S_WR_RPLY: begin
        if (!rdout_q) begin
          trply_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifdef QSLAVE_DATIO_EN
        // Second half of DATIO: one write allowed after the read within the same RSYNC.
        if (did_read_q && rdout_q && iWRITE_MATCH) begin
          wdata_d    = dal_q;
          byte_d     = rwtbt_q;
          write_d    = 1'b1;
          did_read_d = 1'b0;
          state_d    = S_WR;
        end
`endif
      end
      S_SKIP: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_q != S_IDLE && !rsync_q) begin
      state_d = S_IDLE;
      daltx_d = 1'b0;
      trply_d = 1'b0;
      write_d = 1'b0;
    end
  end

  assign DAL    = daltx_q ? {6'b000000, rdata_q} : 22'bz;
  assign DALtx  = daltx_q;
  assign TRPLY  = trply_q;
  assign iADDR  = addr_q;
  assign iBS7   = bs7_q;
  assign iWRITE = write_q;
  assign iBYTE  = byte_q;
  assign iWDATA = wdata_q;

endmodule

// File: tb/tb_qbus_slave.sv
// tb/tb_qbus_slave.sv - directed self-checking bench for qbus_slave.
module tb_qbus_slave;

  logic        qclk;
  logic        reset;
  wire  [21:0] DAL;
  logic [21:0] dal_drv;
  logic        dal_oe;
  logic        DALtx;
  logic        RSYNC, RDIN, RDOUT, RBS7, RWTBT, RINIT;
  logic        TRPLY;
  logic [12:0] iADDR;
  logic        iBS7, iWRITE, iBYTE;
  logic [15:0] iWDATA;
  logic [15:0] iRDATA;
  logic        iREAD_MATCH, iWRITE_MATCH;

  int checks = 0;
  int errors = 0;
  int n_rply, n_wr, n_daltx;
  logic trply_prev = 1'b0;

  assign DAL = dal_oe ? dal_drv : 22'bz;

  qbus_slave #(.REPLY_DELAY(1), .ADDR_BITS(13)) dut (
    .qclk(qclk), .reset(reset), .DAL(DAL), .DALtx(DALtx),
    .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RBS7(RBS7), .RWTBT(RWTBT), .RINIT(RINIT),
    .TRPLY(TRPLY), .iADDR(iADDR), .iBS7(iBS7), .iWRITE(iWRITE), .iBYTE(iBYTE),
    .iWDATA(iWDATA), .iRDATA(iRDATA), .iREAD_MATCH(iREAD_MATCH), .iWRITE_MATCH(iWRITE_MATCH)
  );

  initial qclk = 1'b0;
  always #25 qclk = ~qclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge qclk);
    #1;
    if (TRPLY && !trply_prev) n_rply++;
    trply_prev = TRPLY;
    if (iWRITE) n_wr++;
    if (DALtx) n_daltx++;
  endtask

  task automatic clear_counts();
    n_rply = 0; n_wr = 0; n_daltx = 0;
  endtask

  task automatic start_cycle(input logic [21:0] addr, input logic bs7);
    dal_drv = addr; dal_oe = 1'b1; RBS7 = bs7; RSYNC = 1'b1;
    tick();
    dal_oe = 1'b0; RBS7 = 1'b0;
  endtask

  task automatic end_cycle();
    RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; dal_oe = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_trply(input string tag, input logic level);
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TRPLY == level) begin ok = 1'b1; break; end
    end
    check(tag, {31'b0, ok}, 32'd1);
  endtask

  task automatic write_cycle(input logic [12:0] addr, input logic [15:0] data, input logic bw);
    start_cycle({9'b0, addr}, 1'b1);
    dal_drv = {6'b0, data}; dal_oe = 1'b1; RDOUT = 1'b1; RWTBT = bw; iWRITE_MATCH = 1'b1;
    tick();
    check("wr_addr", {19'b0, iADDR}, {19'b0, addr});
    check("wr_strobe_early", {31'b0, iWRITE}, 32'd0);
    tick();
    check("wr_strobe", {31'b0, iWRITE}, 32'd1);
    check("wr_data", {16'b0, iWDATA}, {16'b0, data});
    check("wr_byte", {31'b0, iBYTE}, {31'b0, bw});
    check("wr_rply_early", {31'b0, TRPLY}, 32'd0);
    tick();
    check("wr_strobe_one", {31'b0, iWRITE}, 32'd0);
    check("wr_rply", {31'b0, TRPLY}, 32'd1);
    tick();
    RDOUT = 1'b0;
    tick();
    check("wr_rply_hold", {31'b0, TRPLY}, 32'd1);
    tick();
    check("wr_rply_drop", {31'b0, TRPLY}, 32'd0);
    RWTBT = 1'b0;
    end_cycle();
  endtask

  initial begin
    reset = 1'b1; RSYNC = 0; RDIN = 0; RDOUT = 0; RBS7 = 0; RWTBT = 0; RINIT = 0;
    dal_drv = '0; dal_oe = 1'b0; iRDATA = 16'o123456; iREAD_MATCH = 0; iWRITE_MATCH = 0;
    clear_counts();
    repeat (3) tick();
    check("rst_daltx", {31'b0, DALtx}, 32'd0);
    check("rst_trply", {31'b0, TRPLY}, 32'd0);
    check("rst_iwrite", {31'b0, iWRITE}, 32'd0);
    check("rst_ibyte", {31'b0, iBYTE}, 32'd0);
    check("rst_iaddr", {19'b0, iADDR}, 32'd0);
    check("rst_iwdata", {16'b0, iWDATA}, 32'd0);
    reset = 1'b0;
    tick();

    // DATI at 17772, REPLY_DELAY=1
    iREAD_MATCH = 1'b1;
    start_cycle(22'o17772, 1'b1);
    RDIN = 1'b1;
    tick();
    check("rd_addr", {19'b0, iADDR}, 32'o17772);
    check("rd_bs7", {31'b0, iBS7}, 32'd1);
    tick();
    check("rd_daltx_early", {31'b0, DALtx}, 32'd0);
    tick();
    check("rd_daltx", {31'b0, DALtx}, 32'd1);
    check("rd_trply_early", {31'b0, TRPLY}, 32'd0);
    check("rd_dal", {10'b0, DAL}, 32'o123456);
    tick();
    check("rd_trply", {31'b0, TRPLY}, 32'd1);
    RDIN = 1'b0;
    tick();
    check("rd_trply_hold", {31'b0, TRPLY}, 32'd1);
    tick();
    check("rd_trply_drop", {31'b0, TRPLY}, 32'd0);
    check("rd_daltx_drop", {31'b0, DALtx}, 32'd0);
    end_cycle();

    // reset asserted while replying to a read
    start_cycle(22'o17772, 1'b1);
    RDIN = 1'b1;
    wait_trply("mr_wait", 1'b1);
    reset = 1'b1;
    tick();
    check("mr_trply", {31'b0, TRPLY}, 32'd0);
    check("mr_daltx", {31'b0, DALtx}, 32'd0);
    check("mr_iaddr", {19'b0, iADDR}, 32'd0);
    tick();
    reset = 1'b0;
    end_cycle();

    write_cycle(13'o17774, 16'o000777, 1'b0);
    write_cycle(13'o17775, 16'o000377, 1'b1);
    check("wb_addr0", {31'b0, iADDR[0]}, 32'd1);

    // unclaimed reads: no BS7, then no register match
    clear_counts();
    start_cycle(22'o17772, 1'b0);
    RDIN = 1'b1;
    repeat (8) tick();
    end_cycle();
    check("nobs7_rply", n_rply, 32'd0);
    check("nobs7_daltx", n_daltx, 32'd0);
    iREAD_MATCH = 1'b0;
    clear_counts();
    start_cycle(22'o17772, 1'b1);
    RDIN = 1'b1;
    repeat (8) tick();
    end_cycle();
    check("nomatch_rply", n_rply, 32'd0);
    check("nomatch_daltx", n_daltx, 32'd0);

    // DIN followed by DOUT in one RSYNC
    iREAD_MATCH = 1'b1;
    iWRITE_MATCH = 1'b1;
    clear_counts();
    start_cycle(22'o17772, 1'b1);
    RDIN = 1'b1;
    wait_trply("rmw_rd", 1'b1);
    RDIN = 1'b0;
    wait_trply("rmw_rd_end", 1'b0);
    dal_drv = 22'o000001; dal_oe = 1'b1; RDOUT = 1'b1;
    repeat (6) tick();
    RDOUT = 1'b0;
    repeat (4) tick();
    end_cycle();
`ifdef QSLAVE_DATIO_EN
    check("rmw_rply", n_rply, 32'd2);
    check("rmw_wr", n_wr, 32'd1);
    check("rmw_wdata", {16'b0, iWDATA}, 32'd1);
`else
    check("rmw_rply", n_rply, 32'd1);
    check("rmw_wr", n_wr, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qbus_slave.md
Name: qbus_slave

Overview:
- QBUS bus-slave (target) engine: the responding end of the DATI/DATO/DATOB/DATIO cycles issued by `master`.
- Watches the received QBUS signals from `qdrv` and captures the cycle address.
- Presents accesses on the internal I/O bus (iADDR/iBS7/iWRITE/iWDATA/iRDATA/iREAD_MATCH/iWRITE_MATCH) and drives DAL and TRPLY back through `qdrv`.
- Only I/O-page (BS7) cycles that a register block claims are answered; every other cycle gets no reply, so the master times out (NXM).

Parameters:
- REPLY_DELAY, 1: qclk cycles between DALtx/data valid and TRPLY assertion on reads (1..7).
- ADDR_BITS, 13: width of iADDR (low address bits of the I/O page).

Ports:
- qclk  input  1  system clock, 20 MHz.
- reset  input  1  synchronous, active-high reset.
- DAL  inout  22  bidirectional DAL to qdrv; driven only when DALtx=1.
- DALtx  output  1  DAL direction: 1 = FPGA drives DAL.
- RSYNC, RDIN, RDOUT, RBS7, RWTBT, RINIT  input  1 each  received bus signals, true = asserted.
- TRPLY  output  1  assert BRPLY.
- iADDR  output  ADDR_BITS  latched address, bit 0 = byte select.
- iBS7  output  1  latched BS7.
- iWRITE  output  1  one-cycle write strobe.
- iBYTE  output  1  1 = byte write (DATOB); byte selected by iADDR[0].
- iWDATA  output  16  write data.
- iRDATA  input  16  read data from the matching register.
- iREAD_MATCH, iWRITE_MATCH  input  1 each  a register decodes iADDR/iBS7 for read/write.

Behaviour:
- Reset or RINIT values: state IDLE; DALtx=0, TRPLY=0, iWRITE=0, iBYTE=0, iBS7=0, iADDR=0, iWDATA=0, DAL=Z.
  - Either reset source takes effect on the next edge, from any state, mid-cycle included.
- Inputs are registered once; all decisions use these registered copies.
- Address capture:
  - Address is taken from DAL[ADDR_BITS-1:0] and RBS7 on the first edge where RSYNC is seen high.
  - It stays stable until RSYNC negates.
- States:
  - IDLE: RSYNC rises → capture address → ADDR.
  - ADDR:
    - RSYNC low → IDLE.
    - iBS7=0 → SKIP.
    - RDIN & iREAD_MATCH → RD_LATCH.
    - RDOUT & iWRITE_MATCH → WR.
    - RDIN/RDOUT without a match → SKIP.
  - RD_LATCH: register iRDATA; next edge DALtx=1, DAL[15:0]=data, DAL[21:16]=0 → RD_DRV.
  - RD_DRV: after REPLY_DELAY cycles TRPLY=1 → RD_RPLY.
  - RD_RPLY: hold DALtx, DAL and TRPLY until RDIN low; then DALtx=0, TRPLY=0 on the same edge → DONE.
  - WR:
    - iWDATA=DAL[15:0], iBYTE=RWTBT, iWRITE=1 for exactly one cycle.
    - Next edge TRPLY=1 → WR_RPLY.
  - WR_RPLY: TRPLY held until RDOUT low, then TRPLY=0 → DONE.
  - DONE: wait for RSYNC low → IDLE (DATIO handling: see Optional Feature).
  - SKIP: no outputs asserted; wait for RSYNC low → IDLE.
- RSYNC negating in any state other than IDLE: DALtx, TRPLY and iWRITE go to 0 on the next edge and the state returns to IDLE (aborted cycle).
- RDIN and RDOUT both high in ADDR: RDIN wins.
- Never asserts TDMR/TSACK or any other bus line.
- Read latency: 2 + REPLY_DELAY edges from registered RDIN to TRPLY.
- Write latency: 1 edge to iWRITE, 2 edges to TRPLY.

Optional Feature:
- Macro QSLAVE_DATIO_EN.
- Defined:
  - in DONE after a read, RDOUT with iWRITE_MATCH → WR, completing the DATIO/DATIOB read-modify-write in the same RSYNC.
  - RWTBT selects byte as usual.
- Undefined:
  - DONE ignores RDOUT; only one data transfer per RSYNC; a second DOUT gets no reply.

Test Plan:
- Reset for 2 cycles mid-read (TRPLY=1) → next edge TRPLY=0, DALtx=0, state IDLE, DAL=Z.
- DATI at BS7 addr 0o17772 with iREAD_MATCH=1, iRDATA=0o123456, REPLY_DELAY=1 → DAL=0o123456 and DALtx=1 one cycle before TRPLY; both drop on the edge after RDIN low.
- DATO addr 0o17774, DAL data 0o000777, RWTBT=0 → one-cycle iWRITE, iWDATA=0o000777, iBYTE=0, then TRPLY until RDOUT low.
- DATOB at odd addr 0o17775, RWTBT=1 → iBYTE=1, iADDR[0]=1.
- DATI with RBS7=0, or with iREAD_MATCH=0 → TRPLY and DALtx never assert; idle once RSYNC low.
- QSLAVE_DATIO_EN set, DIN then DOUT in one RSYNC, data 0o000001 → two TRPLY pulses and one iWRITE.
- QSLAVE_DATIO_EN clear, DIN then DOUT in one RSYNC, data 0o000001 → one TRPLY pulse, no iWRITE.
